blink_gen: RTL and testbench
============================

BLINK_GEN -- requirements
Module: blink_gen

Interface
REQ-001 The block SHALL have parameter WIN_INIT, default 1000, initial response-window length in clk cycles.
REQ-002 The block SHALL have parameter WIN_MIN, default 100, minimum response-window length in cycles.
REQ-003 The block SHALL have parameter WIN_STEP, default 50, window shrink per successful round.
REQ-004 The block SHALL have parameter GAP_MIN, default 200, minimum dark gap between targets in cycles.
REQ-005 The block SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-006 The block SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-007 The block SHALL have port start  input  1  begin a new game, sampled on clk.
REQ-008 The block SHALL have port stop  input  1  abort to idle, sampled on clk.
REQ-009 The block SHALL have port hit  input  1  correct player response, from the loss detector.
REQ-010 The block SHALL have port lose  input  1  wrong player response, from the loss detector.
REQ-011 The block SHALL have port led  output  4  one-hot target LED drive.
REQ-012 The block SHALL have port win_en  output  1  response window open, drives the loss detector enable.
REQ-013 The block SHALL have port score  output  8  successful rounds in the current game.
REQ-014 The block SHALL have port game_over  output  1  game ended by loss or timeout.

Function
REQ-015 The FSM SHALL have states IDLE, GAP, SHOW and OVER, one-hot or binary at implementer's choice.
REQ-016 IDLE: led=0, win_en=0, game_over=0; start -> GAP next cycle, score:=0, win_len:=WIN_INIT.
REQ-017 GAP: led=0, win_en=0; lasts exactly gap_len cycles, then -> SHOW with target latched on GAP entry.
REQ-018 SHOW: led=one-hot(target), win_en=1; lasts at most win_len cycles.
REQ-019 In SHOW, lose=1 -> OVER next cycle, score unchanged.
REQ-020 In SHOW, hit=1 with lose=0 -> GAP next cycle, score:=score+1 (saturating at 255), win_len:=max(win_len-WIN_STEP, WIN_MIN).
REQ-021 hit and lose in the same SHOW cycle SHALL be treated as lose.
REQ-022 hit on the final SHOW cycle SHALL count as a hit; no hit/lose by the end of win_len cycles -> OVER (timeout).
REQ-023 hit/lose outside SHOW SHALL be ignored.
REQ-024 OVER: led=4'hF, win_en=0, game_over=1, score held; start -> GAP with score:=0, win_len:=WIN_INIT.
REQ-025 stop=1 in any state SHALL force IDLE next cycle; stop takes priority over start, hit and lose.
REQ-026 win_len and cycle counters SHALL be 16 bits; parameters above 65535 are illegal.

Reset
REQ-027 On reset=1, asynchronously: state=IDLE, led=0, win_en=0, score=0, game_over=0, win_len=WIN_INIT, target=0, LFSR=16'hACE1.
REQ-028 Reset mid-SHOW SHALL drop win_en to 0 immediately, with no score update.

Configuration
REQ-029 With BLINK_GEN_LFSR_EN defined, the block SHALL contain a 16-bit Galois LFSR (taps 16,14,13,11) advancing every cycle.
REQ-030 With BLINK_GEN_LFSR_EN defined, target SHALL be lfsr[1:0] and gap_len SHALL be GAP_MIN+lfsr[9:2], sampled on GAP entry.
REQ-031 With BLINK_GEN_LFSR_EN undefined, there SHALL be no LFSR; target SHALL rotate 0,1,2,3,0... (first target 0 after start) and gap_len SHALL be GAP_MIN.

Verification (params WIN_INIT=8, WIN_MIN=4, WIN_STEP=2, GAP_MIN=3, macro undefined unless stated)
REQ-032 reset, start pulse -> 3 cycles led=0, then led=4'b0001, win_en=1 for 8 cycles; no hit -> game_over=1, led=4'hF, score=0.
REQ-033 hit on 2nd SHOW cycle for 4 rounds -> score 1,2,3,4; window lengths 8,6,4,4; led 0001,0010,0100,1000.
REQ-034 hit and lose in the same SHOW cycle -> OVER next cycle, score unchanged.
REQ-035 reset during SHOW -> win_en=0 immediately; start -> score=0, first window 8 cycles.
REQ-036 stop during GAP with start high -> IDLE next cycle, all outputs 0.
REQ-037 BLINK_GEN_LFSR_EN defined -> targets and gaps match the reference LFSR sequence from seed 16'hACE1; gap is always in 3..258.

Source files
------------

// File: rtl/blink_gen.sv
// rtl/blink_gen.sv - reaction-game target/window sequencer.
// Define BLINK_GEN_LFSR_EN for pseudo-random targets and gaps; otherwise targets rotate and the gap is fixed.
module blink_gen #(
  parameter int unsigned WIN_INIT = 1000,
  parameter int unsigned WIN_MIN  = 100,
  parameter int unsigned WIN_STEP = 50,
  parameter int unsigned GAP_MIN  = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       hit,
  input  logic       lose,
  output logic [3:0] led,
  output logic       win_en,
  output logic [7:0] score,
  output logic       game_over
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GAP  = 2'd1;
  localparam logic [1:0] S_SHOW = 2'd2;
  localparam logic [1:0] S_OVER = 2'd3;

  localparam logic [15:0] WIN_INIT_W   = 16'(WIN_INIT);
  localparam logic [15:0] WIN_MIN_W    = 16'(WIN_MIN);
  localparam logic [15:0] WIN_STEP_W   = 16'(WIN_STEP);
  localparam logic [15:0] GAP_MIN_W    = 16'(GAP_MIN);
  localparam logic [16:0] SHRINK_FLOOR = 17'(WIN_MIN) + 17'(WIN_STEP);

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] win_len_q, win_len_d;
  logic [1:0]  target_q, target_d;
  logic [7:0]  score_q, score_d;
  logic [15:0] win_len_shrunk;
  logic [15:0] gap_len_cur;
  logic [1:0]  target_first;
  logic [1:0]  target_after_hit;
  logic        gap_load;

`ifdef BLINK_GEN_LFSR_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic [15:0] gap_len_q;

  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
  assign lfsr_d           = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign target_first     = lfsr_q[1:0];
  assign target_after_hit = lfsr_q[1:0];
  assign gap_len_cur      = gap_len_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q    <= 16'hACE1;
      gap_len_q <= GAP_MIN_W;
    end else begin
      lfsr_q <= lfsr_d;
      if (gap_load) begin
        gap_len_q <= GAP_MIN_W + {8'h00, lfsr_q[9:2]};
      end
    end
  end
`else
  assign target_first     = 2'd0;
  assign target_after_hit = target_q + 2'd1;
  assign gap_len_cur      = GAP_MIN_W;
`endif

  assign win_len_shrunk = ({1'b0, win_len_q} >= SHRINK_FLOOR) ? (win_len_q - WIN_STEP_W) : WIN_MIN_W;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    win_len_d = win_len_q;
    target_d  = target_q;
    score_d   = score_q;
    gap_load  = 1'b0;
    if (stop) begin
      state_d = S_IDLE;
      cnt_d   = 16'd0;
      score_d = 8'd0;
    end else begin
      case (state_q)
        S_IDLE, S_OVER: begin
          if (start) begin
            state_d   = S_GAP;
            cnt_d     = 16'd0;
            score_d   = 8'd0;
            win_len_d = WIN_INIT_W;
            target_d  = target_first;
            gap_load  = 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_q == gap_len_cur - 16'd1) begin
            state_d = S_SHOW;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        S_SHOW: begin
          // lose outranks hit, and hit outranks the window expiring on the same cycle
          if (lose) begin
            state_d = S_OVER;
            cnt_d   = 16'd0;
          end else if (hit) begin
            state_d   = S_GAP;
            cnt_d     = 16'd0;
            score_d   = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
            win_len_d = win_len_shrunk;
            target_d  = target_after_hit;
            gap_load  = 1'b1;
          end else if (cnt_q == win_len_q - 16'd1) begin
            state_d = S_OVER;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 16'd0;
      win_len_q <= WIN_INIT_W;
      target_q  <= 2'd0;
      score_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      win_len_q <= win_len_d;
      target_q  <= target_d;
      score_q   <= score_d;
    end
  end

  always_comb begin
    led       = 4'h0;
    win_en    = 1'b0;
    game_over = 1'b0;
    case (state_q)
      S_SHOW: begin
        led    = 4'b0001 << target_q;
        win_en = 1'b1;
      end
      S_OVER: begin
        led       = 4'hF;
        game_over = 1'b1;
      end
      default: ;
    endcase
  end

  assign score = score_q;

endmodule

// File: tb/tb_blink_gen.sv
// tb/tb_blink_gen.sv - self-checking bench for blink_gen (vector table, corner sequences, random vs game model).
// Honours BLINK_GEN_LFSR_EN the same way the design does.
module tb_blink_gen;

  localparam int WIN_INIT = 8;
  localparam int WIN_MIN  = 4;
  localparam int WIN_STEP = 2;
  localparam int GAP_MIN  = 3;

  localparam int P_IDLE = 0;
  localparam int P_GAP  = 1;
  localparam int P_SHOW = 2;
  localparam int P_OVER = 3;

  logic       clk;
  logic       reset, start, stop, hit, lose;
  logic [3:0] led;
  logic       win_en, game_over;
  logic [7:0] score;

  blink_gen #(
    .WIN_INIT(WIN_INIT), .WIN_MIN(WIN_MIN), .WIN_STEP(WIN_STEP), .GAP_MIN(GAP_MIN)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .hit(hit), .lose(lose),
    .led(led), .win_en(win_en), .score(score), .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Game model: phase plus cycles remaining in that phase
  int          m_phase, m_left, m_score, m_win, m_target;
  logic [15:0] m_lfsr;

  typedef struct packed {
    logic       start, stop, hit, lose;
    logic [3:0] led;
    logic       win_en;
    logic [7:0] score;
    logic       game_over;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic p, logic h, logic l, logic [3:0] e_led,
                              logic e_win, logic [7:0] e_score, logic e_go);
    vec_t v;
    v.start = s; v.stop = p; v.hit = h; v.lose = l;
    v.led = e_led; v.win_en = e_win; v.score = e_score; v.game_over = e_go;
    return v;
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_phase = P_IDLE; m_left = 0; m_score = 0; m_win = WIN_INIT; m_target = 0;
    m_lfsr = 16'hACE1;
  endfunction

  function automatic void open_gap();
    m_phase = P_GAP;
`ifdef BLINK_GEN_LFSR_EN
    m_target = int'(m_lfsr[1:0]);
    m_left   = GAP_MIN + int'(m_lfsr[9:2]);
`else
    m_target = (m_target + 1) % 4;
    m_left   = GAP_MIN;
`endif
  endfunction

  function automatic void model_step();
    if (stop) begin
      m_phase = P_IDLE;
      m_score = 0;
    end else if (m_phase == P_IDLE || m_phase == P_OVER) begin
      if (start) begin
        m_score  = 0;
        m_win    = WIN_INIT;
        m_target = 3;
        open_gap();
      end
    end else if (m_phase == P_GAP) begin
      m_left--;
      if (m_left == 0) begin
        m_phase = P_SHOW;
        m_left  = m_win;
      end
    end else begin
      if (lose) m_phase = P_OVER;
      else if (hit) begin
        if (m_score < 255) m_score++;
        m_win = (m_win - WIN_STEP < WIN_MIN) ? WIN_MIN : m_win - WIN_STEP;
        open_gap();
      end else begin
        m_left--;
        if (m_left == 0) m_phase = P_OVER;
      end
    end
    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  endfunction

  task automatic check_outputs(string tag);
    logic [3:0] one;
    logic [3:0] e_led;
    one   = 4'b0001;
    e_led = (m_phase == P_SHOW) ? (one << m_target) : (m_phase == P_OVER) ? 4'hF : 4'h0;
    cmp(tag, 32'({led, win_en, score, game_over}),
        32'({e_led, m_phase == P_SHOW, 8'(m_score), m_phase == P_OVER}));
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    model_step();
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset(string tag);
    reset = 1'b1; start = 1'b0; stop = 1'b0; hit = 1'b0; lose = 1'b0;
    model_reset();
    #1;
    check_outputs(tag);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Called while in the first GAP cycle; returns number of GAP cycles observed
  task automatic wait_show(output int gap);
    gap = 1;
    while (win_en !== 1'b1 && gap < 400) begin
      tick("gap_cycle");
      if (win_en !== 1'b1) gap++;
    end
    n_cmp++;
    if (win_en !== 1'b1) begin
      n_bad++;
      $display("FAIL wait_show: window never opened after %0d cycles", gap);
    end
`ifdef BLINK_GEN_LFSR_EN
    n_cmp++;
    if (gap < 3 || gap > 258) begin
      n_bad++;
      $display("FAIL gap_range: got %0d required 3..258", gap);
    end
`else
    cmp("gap_len", 32'(gap), 32'd3);
`endif
  endtask

  // Called in the first SHOW cycle with no response; returns window length
  task automatic measure_window(output int w);
    w = 1;
    while (w < 400) begin
      tick("show_cycle");
      if (win_en !== 1'b1) break;
      w++;
    end
  endtask

  initial begin
    int g, w;
    logic [3:0] e_led;
    reset = 1'b1; start = 1'b0; stop = 1'b0; hit = 1'b0; lose = 1'b0;

    do_reset("reset_model");
    cmp("reset_outputs", 32'({led, win_en, score, game_over}), 32'd0);

`ifndef BLINK_GEN_LFSR_EN
    // Start pulse, 3 dark cycles, 8-cycle window on LED 0, timeout, then ignored responses
    vecs.push_back(mk(1, 0, 0, 0, 4'h0, 0, 8'd0, 0));
    for (int i = 0; i < 2; i++) vecs.push_back(mk(0, 0, 0, 0, 4'h0, 0, 8'd0, 0));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 0, 0, 0, 4'h1, 1, 8'd0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4'hF, 0, 8'd0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 4'hF, 0, 8'd0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 4'hF, 0, 8'd0, 1));
    foreach (vecs[i]) begin
      start = vecs[i].start; stop = vecs[i].stop; hit = vecs[i].hit; lose = vecs[i].lose;
      tick($sformatf("vec%0d_model", i));
      cmp($sformatf("vec%0d", i), 32'({led, win_en, score, game_over}),
          32'({vecs[i].led, vecs[i].win_en, vecs[i].score, vecs[i].game_over}));
    end
    hit = 1'b0; lose = 1'b0;
`endif

    // Four rounds hit on the second SHOW cycle, then a timeout at the floor window
    start = 1'b1; tick("r_start"); start = 1'b0;
    for (int r = 0; r < 4; r++) begin
      wait_show(g);
`ifndef BLINK_GEN_LFSR_EN
      e_led = 4'b0001 << r;
      cmp($sformatf("round%0d_led", r), 32'(led), 32'(e_led));
`endif
      tick("r_show2");
      hit = 1'b1; tick("r_hit"); hit = 1'b0;
      cmp($sformatf("round%0d_score", r), 32'(score), 32'(r + 1));
    end
    wait_show(g);
    measure_window(w);
    cmp("floor_window", 32'(w), 32'(WIN_MIN));
    cmp("floor_timeout_over", 32'({led, game_over, score}), 32'({4'hF, 1'b1, 8'd4}));

    // Simultaneous hit and lose counts as a loss
    start = 1'b1; tick("hl_start"); start = 1'b0;
    wait_show(g);
    hit = 1'b1; tick("hl_hit"); hit = 1'b0;
    wait_show(g);
    hit = 1'b1; lose = 1'b1; tick("hl_both"); hit = 1'b0; lose = 1'b0;
    cmp("hit_lose_over", 32'({led, win_en, score, game_over}), 32'({4'hF, 1'b0, 8'd1, 1'b1}));

    // Reset inside SHOW, then a fresh game gets the full initial window
    start = 1'b1; tick("rs_start"); start = 1'b0;
    wait_show(g);
    hit = 1'b1; tick("rs_hit"); hit = 1'b0;
    wait_show(g);
    tick("rs_show2");
    reset = 1'b1;
    #1;
    cmp("reset_drops_win_en", 32'(win_en), 32'd0);
    do_reset("reset_in_show");
    start = 1'b1; tick("rs_restart"); start = 1'b0;
    cmp("restart_score", 32'(score), 32'd0);
    wait_show(g);
    measure_window(w);
    cmp("restart_window", 32'(w), 32'(WIN_INIT));

    // stop beats start during GAP
    start = 1'b1; tick("st_start"); start = 1'b0;
    stop = 1'b1; start = 1'b1; tick("st_stop"); stop = 1'b0; start = 1'b0;
    cmp("stop_idle", 32'({led, win_en, score, game_over}), 32'd0);
    tick("st_idle_hold");
    cmp("stop_idle_hold", 32'({led, win_en, score, game_over}), 32'd0);

    // Random play against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(999) == 0) begin
        do_reset("rand_reset");
      end else begin
        start = ($urandom_range(99) < 4);
        stop  = ($urandom_range(199) == 0);
        hit   = ($urandom_range(99) < 18);
        lose  = ($urandom_range(99) < 4);
        tick("rand");
      end
    end
    start = 1'b0; stop = 1'b0; hit = 1'b0; lose = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
